serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer around one full-adder cell.
// Operands are captured on start, added LSB-first one bit per clock through
// a carry flop, and the assembled sum is published with a one-cycle done.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one operand bit processed per clock, busy high
// DONE  | done pulse; a start seen here begins the next addition at once
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             cell_s;
    logic             cell_c;
    logic             last;

    // Full-adder cell and last-bit detect
    always_comb begin
        cell_s = a_sh[0] ^ b_sh[0] ^ carry;
        cell_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last   = (cnt == CW'(WIDTH - 1));
    end

    // Sequencer, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        sum_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
                    carry  <= cell_c;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        // carry still holds the carry into the MSB here
                        sum   <= {cell_s, sum_sh[WIDTH-1:1]};
                        cout  <= cell_c;
                        ovf   <= carry ^ cell_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int         checks;
    int         errors;
    logic [7:0] prev_sum;

    serial_adder_ctrl #(.WIDTH(8), .CW(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // behavioural reference: {ovf, cout, sum}
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mc);
        logic [8:0] t;
        logic       v;
        t = {1'b0, ma} + {1'b0, mb} + {8'd0, mc};
        v = (ma[7] == mb[7]) && (t[7] != ma[7]);
        return {v, t};
    endfunction

    // one addition from IDLE, checking timing, stability and result
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic [7:0] es, input logic ec, input logic eo, input string tag);
        int   nbusy;
        int   idx;
        logic seen;
        logic stable;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
        nbusy = 0; idx = 0; seen = 1'b0; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (sum !== prev_sum) stable = 1'b0;
            idx++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(idx), 32'd8);
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
        check({tag, "_sum_stable"}, 32'(stable), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        prev_sum = es;
        @(negedge clk);
        check({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        int         ndone;
        int         pos[3];
        int         np;
        logic [7:0] got;
        logic [9:0] m;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        checks = 0; errors = 0; prev_sum = 8'h00;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01");
        run_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, "aa_55_c");
        run_op(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, "80_ff");

        for (int i = 0; i < 8; i++) begin
            ra = {7'd0, i[2]}; rb = {7'd0, i[1]}; rc = i[0];
            m = model(ra, rb, rc);
            run_op(ra, rb, rc, m[7:0], m[8], m[9], "fa_row");
        end

        // start pulsed mid-RUN with new operands must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h33; b = 8'hCC;
        ndone = 0; got = 8'h00;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                ndone++;
                got = sum;
            end
            @(negedge clk);
        end
        check("midrun_done_count", 32'(ndone), 32'd1);
        check("midrun_sum", 32'(got), 32'h30);
        check("midrun_busy_after", 32'(busy), 32'd0);
        prev_sum = 8'h30;

        // start held high: accepted once per 9 clocks
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        np = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done && np < 3) begin
                pos[np] = i;
                np++;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(np), 32'd3);
        check("b2b_first", 32'(pos[0]), 32'd8);
        check("b2b_second", 32'(pos[1]), 32'd17);
        check("b2b_third", 32'(pos[2]), 32'd26);
        check("b2b_sum", 32'(sum), 32'h03);
        for (int i = 0; i < 12; i++) @(negedge clk);
        prev_sum = 8'h03;

        // reset in the middle of RUN
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "pre_rst");
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        prev_sum = 8'h00;
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            m = model(ra, rb, rc);
            run_op(ra, rb, rc, m[7:0], m[8], m[9], "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
